e_mdu: RTL and testbench

- Multiply/divide unit in the E stage, beside the ALU.
- It consumes the forwarded rs/rt operands that the E stage already produces.
- It holds the architectural HI/LO registers and runs multi-cycle mult/div operations.
- It raises a stall request so that D-stage multiply/divide/HI/LO instructions are held while an operation is in flight.

---
 rtl/e_mdu_if.sv | 22 ++
 rtl/e_mdu.sv | 174 +++++++++++++++++
 tb/tb_e_mdu.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_if.sv
// E-stage multiply/divide unit bundle: issue side (start/op/operands) and
// result side (busy/stall/HI/LO).
interface e_mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, src_a, src_b,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, mdu_op, src_a, src_b,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding architectural HI/LO.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accumulate ops).
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_mult, is_div, is_mthi, is_mtlo;
    logic               is_acc, acc_sub, op_signed;
    logic               long_op;

    logic [63:0]        a_ext, b_ext, prod, acc, mult_res;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

    // Opcode decode; accumulate codes only decode when the feature is built in
    always_comb begin
        is_mult   = 1'b0;
        is_div    = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        is_acc    = 1'b0;
        acc_sub   = 1'b0;
        op_signed = 1'b0;
        case (bus.mdu_op)
            OP_MULT:  begin is_mult = 1'b1; op_signed = 1'b1; end
            OP_MULTU: begin is_mult = 1'b1; end
            OP_DIV:   begin is_div  = 1'b1; op_signed = 1'b1; end
            OP_DIVU:  begin is_div  = 1'b1; end
            OP_MTHI:  begin is_mthi = 1'b1; end
            OP_MTLO:  begin is_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mult = 1'b1; is_acc = 1'b1; op_signed = 1'b1; end
            OP_MADDU: begin is_mult = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mult = 1'b1; is_acc = 1'b1; acc_sub = 1'b1; op_signed = 1'b1; end
            OP_MSUBU: begin is_mult = 1'b1; is_acc = 1'b1; acc_sub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    assign long_op = is_mult | is_div;

    // Product is formed on sign/zero-extended 64-bit operands so the low
    // 64 bits are correct for both signed and unsigned multiplies.
    always_comb begin
        a_ext    = op_signed ? {{32{bus.src_a[31]}}, bus.src_a} : {32'b0, bus.src_a};
        b_ext    = op_signed ? {{32{bus.src_b[31]}}, bus.src_b} : {32'b0, bus.src_b};
        prod     = a_ext * b_ext;
        acc      = {hi_q, lo_q};
        mult_res = prod;
        if (is_acc) begin
            mult_res = acc_sub ? (acc - prod) : (acc + prod);
        end
    end

    // Signed divide via magnitudes; keeps 0x80000000 / -1 well defined
    always_comb begin
        a_neg  = op_signed & bus.src_a[31];
        b_neg  = op_signed & bus.src_b[31];
        a_mag  = a_neg ? (32'd0 - bus.src_a) : bus.src_a;
        b_mag  = b_neg ? (32'd0 - bus.src_b) : bus.src_b;
        b_safe = (bus.src_b == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_mthi) begin
                        hi_d = bus.src_a;
                    end else if (is_mtlo) begin
                        lo_d = bus.src_a;
                    end else if (is_mult) begin
                        pend_hi_d = mult_res[63:32];
                        pend_lo_d = mult_res[31:0];
                        pend_wr_d = 1'b1;
                        cnt_d     = CNT_W'(MULT_CYCLES);
                        state_d   = S_BUSY;
                    end else if (is_div) begin
                        pend_hi_d = rem;
                        pend_lo_d = quo;
                        // Divide by zero still occupies the unit but commits nothing
                        pend_wr_d = (bus.src_b != '0);
                        cnt_d     = CNT_W'(DIV_CYCLES);
                        state_d   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_wr_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy      = (state_q == S_BUSY);
    assign bus.stall_req = (state_q == S_BUSY) | (bus.start & long_op);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Directed vector bench for e_mdu: HI/LO results, busy length, stall_req,
// async reset mid-operation and start-while-busy.
module tb_e_mdu;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    e_mdu_if bus ();

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_stall;
        int          exp_cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = v.op;
        bus.src_a  = v.a;
        bus.src_b  = v.b;
        #1;
        check({v.name, ".stall"}, 32'(bus.stall_req), 32'(v.exp_stall));
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        #1;
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check({v.name, ".busy_cycles"}, 32'(cyc), 32'(v.exp_cyc));
        check({v.name, ".hi"}, bus.hi, v.exp_hi);
        check({v.name, ".lo"}, bus.lo, v.exp_lo);
    endtask

    initial begin
        int cyc;
        logic stall_bad;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{"mthi",      4'd5,  32'h0000_1234, 32'h0,          1'b0, 0,  32'h0000_1234, 32'h0000_0000};
        vecs[1]  = '{"mtlo",      4'd6,  32'h0000_5678, 32'h0,          1'b0, 0,  32'h0000_1234, 32'h0000_5678};
        vecs[2]  = '{"mult_neg",  4'd1,  32'hFFFF_FFFE, 32'h0000_0003,  1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[3]  = '{"multu_max", 4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b1, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{"div_neg",   4'd3,  32'hFFFF_FFF9, 32'h0000_0002,  1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5]  = '{"divu",      4'd4,  32'h0000_0007, 32'h0000_0002,  1'b1, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[6]  = '{"div_ovf",   4'd3,  32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[7]  = '{"mult_pos",  4'd1,  32'h0000_0007, 32'h0000_0003,  1'b1, 5,  32'h0000_0000, 32'h0000_0015};
        vecs[8]  = '{"div_negb",  4'd3,  32'h0000_0064, 32'hFFFF_FFF9,  1'b1, 10, 32'h0000_0002, 32'hFFFF_FFF2};
        vecs[9]  = '{"op_none",   4'd0,  32'hDEAD_BEEF, 32'h1,          1'b0, 0,  32'h0000_0002, 32'hFFFF_FFF2};
        vecs[10] = '{"op_bad",    4'd12, 32'hDEAD_BEEF, 32'h1,          1'b0, 0,  32'h0000_0002, 32'hFFFF_FFF2};
        vecs[11] = '{"mthi0",     4'd5,  32'h0000_0000, 32'h0,          1'b0, 0,  32'h0000_0000, 32'hFFFF_FFF2};
        vecs[12] = '{"mtlo1s",    4'd6,  32'hFFFF_FFFF, 32'h0,          1'b0, 0,  32'h0000_0000, 32'hFFFF_FFFF};
`ifdef MDU_MADD_EN
        vecs[13] = '{"madd",      4'd7,  32'h0000_0001, 32'h0000_0001,  1'b1, 5,  32'h0000_0001, 32'h0000_0000};
        vecs[14] = '{"msub",      4'd9,  32'h0000_0001, 32'h0000_0001,  1'b1, 5,  32'h0000_0000, 32'hFFFF_FFFF};
`else
        vecs[13] = '{"madd",      4'd7,  32'h0000_0001, 32'h0000_0001,  1'b0, 0,  32'h0000_0000, 32'hFFFF_FFFF};
        vecs[14] = '{"msub",      4'd9,  32'h0000_0001, 32'h0000_0001,  1'b0, 0,  32'h0000_0000, 32'hFFFF_FFFF};
`endif

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        bus.src_a  = '0;
        bus.src_b  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.busy",  32'(bus.busy), 32'd0);
        check("reset.stall", 32'(bus.stall_req), 32'd0);
        check("reset.hi",    bus.hi, 32'h0);
        check("reset.lo",    bus.lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Asynchronous reset in the middle of a multiply
        run_vec('{"rst_mthi", 4'd5, 32'h0000_1234, 32'h0, 1'b0, 0, 32'h0000_1234, 32'hFFFF_FFFF});
        run_vec('{"rst_mtlo", 4'd6, 32'h0000_5678, 32'h0, 1'b0, 0, 32'h0000_1234, 32'h0000_5678});
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = 4'd1;
        bus.src_a  = 32'h7;
        bus.src_b  = 32'h3;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        #1;
        check("rst_mult.busy_c1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_now.busy", 32'(bus.busy), 32'd0);
        check("rst_now.hi",   bus.hi, 32'h0);
        check("rst_now.lo",   bus.lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("rst_after.busy", 32'(bus.busy), 32'd0);
        check("rst_after.hi",   bus.hi, 32'h0);
        check("rst_after.lo",   bus.lo, 32'h0);

        // Divide by zero with a multiply held on start for the whole busy window
        run_vec('{"dz_mtlo", 4'd6, 32'h0000_00AA, 32'h0, 1'b0, 0, 32'h0, 32'h0000_00AA});
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = 4'd3;
        bus.src_a  = 32'd5;
        bus.src_b  = 32'd0;
        #1;
        check("dz.stall_start", 32'(bus.stall_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.mdu_op = 4'd1;
        bus.src_a  = 32'd2;
        bus.src_b  = 32'd2;
        #1;
        cyc = 0;
        stall_bad = 1'b0;
        while (bus.busy && cyc < 40) begin
            if (!bus.stall_req) stall_bad = 1'b1;
            cyc++;
            @(negedge clk);
            #1;
        end
        check("dz.busy_cycles", 32'(cyc), 32'd10);
        check("dz.stall_held",  32'(stall_bad), 32'd0);
        check("dz.lo_kept",     bus.lo, 32'h0000_00AA);
        check("dz.hi_kept",     bus.hi, 32'h0);
        check("dz.stall_idle",  32'(bus.stall_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        #1;
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check("dz_mult.busy_cycles", 32'(cyc), 32'd5);
        check("dz_mult.lo", bus.lo, 32'h4);
        check("dz_mult.hi", bus.hi, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
